serial_stream_tx: RTL and testbench
===================================

# serial_stream_tx

Byte-stream transmitter for the scene-record upload protocol. It reads `count` fixed-length records from a synchronous-read record memory and serializes each as command byte `0x01` followed by `DATA_L` payload bytes, least-significant byte first. A stream can optionally begin with a `0x02` (reset-list) command. The block sits between the record memory and a byte-wide UART/link transmitter, and its output is the exact format consumed by the on-chip record receiver.

## Interface

Parameters:
- `DATA_L`, default 27: payload bytes per record.
- `ADDR_W`, default 12: record address and count width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `count`  in  ADDR_W  number of records to send; captured with `start`.
- `clear`  in  1  when high with `start`, emit `0x02` before any record.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a stream completes.
- `rd_en`  out  1  record memory read strobe.
- `rd_addr`  out  ADDR_W  record memory address; valid with `rd_en`.
- `rd_data`  in  DATA_L*8  record word; valid exactly one cycle after `rd_en`.
- `tx_valid`  out  1  `tx_data` holds a byte to transfer.
- `tx_data`  out  8  byte to transmit.
- `tx_ready`  in  1  sink accepts; a transfer happens on a cycle with `tx_valid && tx_ready`.

## Operation

- All outputs are registered. Reset values: `busy=0`, `done=0`, `rd_en=0`, `rd_addr=0`, `tx_valid=0`, `tx_data=0`. Internal state resets to IDLE with the record index and byte counter at 0.
- States:
  - IDLE: on `start`, latch `count` into `remaining` and set index=0. If `clear`=1, go to RST. Otherwise, if count≠0, go to FETCH; if count=0, go to FIN.
  - RST: present `0x02`. On transfer, go to FETCH if `remaining`≠0, else to FIN.
  - FETCH: assert `rd_en` for exactly one cycle with `rd_addr`=index, then go to LOAD.
  - LOAD: capture `rd_data` into a DATA_L*8 shift register, then go to HDR.
  - HDR: present `0x01`. On transfer, load the byte counter with DATA_L−1 and go to DATA.
  - DATA: present the shift register's low byte. On each transfer, shift right by 8. When the counter is 0 at transfer, increment index and decrement `remaining`, then go to FETCH if `remaining`≠0, else to FIN. Otherwise decrement the counter.
  - FIN: assert `done` for one cycle and go to IDLE.
- Handshake:
  - `tx_valid` and `tx_data` stay stable until transfer.
  - `tx_valid` is low in IDLE, FETCH, LOAD and FIN.
  - `tx_ready` is never required before `tx_valid`, and the block never depends on `tx_ready` combinationally.
- `start` while `busy`: ignored. No re-capture of `count` or `clear`.
- Index is ADDR_W bits. The maximum `count` of 2^ADDR_W−1 never wraps the address.
- Byte counter width is $clog2(DATA_L).
- `rst` mid-stream: output stops at once. A partial record is not completed, and the next `start` restarts from address 0. The stream consumer relies on `0x02` resync, so callers set `clear` after any abort.

## Timing

- `start` on cycle 0 with `clear`=1: `tx_valid` high with `0x02` on cycle 1.
- With `clear`=0 and count≠0: `rd_en` on cycle 1, captured on cycle 2, `0x01` presented on cycle 3.
- With `tx_ready` tied high, each record takes DATA_L+3 cycles: FETCH, LOAD, header, then DATA_L bytes.
- The full stream takes 1 + clear + count·(DATA_L+3) cycles from `start` to `done`. `busy` falls on the cycle after `done`.
- `count`=0 with `clear`=0: `done` on cycle 1, `busy` high for exactly that cycle.
- Each `tx_ready` low cycle stalls the stream by exactly one cycle. No byte is dropped or repeated.

## Test plan

- `count`=1, `clear`=1, mem[0] bytes 0x01..0x1B (LSB=0x01), `tx_ready`=1 → bytes 02, 01, 01, 02, …, 1B (29 transfers), single `done` on cycle 32.
- Random `tx_ready` (≈50%) with `count`=4, `clear`=0 → identical byte sequence to the ready-high run, `tx_data` constant whenever `tx_valid && !tx_ready`, `rd_addr` values 0, 1, 2, 3.
- `count`=0, `clear`=0 → no transfers, `done` on cycle 1. `count`=0, `clear`=1 → a single `0x02`, then `done`.
- `start` pulsed mid-stream with a different `count` → ignored, original stream completes unchanged, one `done` only.
- `rst` asserted during the 10th data byte of record 1 → all outputs at reset values in the same cycle. A new `start` with `clear`=1 → stream restarts with `0x02` and `rd_addr`=0.
- Loopback into the record receiver, `count`=3, `clear`=1 → receiver size=3 and stored records 0–2 equal to the source memory.

Source files
------------

// File: rtl/serial_stream_tx_if.sv
// Bus bundle for serial_stream_tx: stream control, record-memory read port and byte-wide TX link.
interface serial_stream_tx_if #(
    parameter int DATA_L = 27,
    parameter int ADDR_W = 12
);
    logic                  start;
    logic [ADDR_W-1:0]     count;
    logic                  clear;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_L*8-1:0]   rd_data;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;

    modport master (
        input  start, count, clear, rd_data, tx_ready,
        output busy, done, rd_en, rd_addr, tx_valid, tx_data
    );

    modport slave (
        output start, count, clear, rd_data, tx_ready,
        input  busy, done, rd_en, rd_addr, tx_valid, tx_data
    );
endinterface

// File: rtl/serial_stream_tx.sv
// Serializes records from a synchronous-read memory as 0x01 + DATA_L payload bytes (LSB first),
// optionally preceded by a 0x02 reset-list command.
module serial_stream_tx #(
    parameter int DATA_L = 27,
    parameter int ADDR_W = 12
) (
    input logic                clk,
    input logic                rst,
    serial_stream_tx_if.master bus
);
    localparam int REC_W = DATA_L * 8;
    localparam int CNT_W = (DATA_L > 1) ? $clog2(DATA_L) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_FETCH, S_LOAD, S_HDR, S_DATA, S_FIN
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   remaining, remaining_n;
    logic [ADDR_W-1:0]   index, index_n;
    logic [CNT_W-1:0]    bcnt, bcnt_n;
    logic [REC_W-1:0]    shreg, shreg_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                rd_en_q, rd_en_n;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_n;
    logic                tx_valid_q, tx_valid_n;
    logic [7:0]          tx_data_q, tx_data_n;
    logic                xfer;

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        index_n     = index;
        bcnt_n      = bcnt;
        shreg_n     = shreg;
        rd_addr_n   = rd_addr_q;
        tx_data_n   = tx_data_q;
        xfer        = tx_valid_q && bus.tx_ready;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    remaining_n = bus.count;
                    index_n     = '0;
                    if (bus.clear)
                        state_n = S_RST;
                    else if (bus.count != '0)
                        state_n = S_FETCH;
                    else
                        state_n = S_FIN;
                end
            end
            S_RST: begin
                if (xfer)
                    state_n = (remaining != '0) ? S_FETCH : S_FIN;
            end
            S_FETCH: state_n = S_LOAD;
            S_LOAD: begin
                shreg_n = bus.rd_data;
                state_n = S_HDR;
            end
            S_HDR: begin
                if (xfer) begin
                    bcnt_n  = CNT_W'(DATA_L - 1);
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shreg_n = shreg >> 8;
                    if (bcnt == '0) begin
                        index_n     = index + ADDR_W'(1);
                        remaining_n = remaining - ADDR_W'(1);
                        state_n     = (remaining_n != '0) ? S_FETCH : S_FIN;
                    end else begin
                        bcnt_n = bcnt - CNT_W'(1);
                    end
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state rather than the current one.
        busy_n     = (state_n != S_IDLE);
        done_n     = (state_n == S_FIN);
        rd_en_n    = (state_n == S_FETCH);
        tx_valid_n = (state_n == S_RST) || (state_n == S_HDR) || (state_n == S_DATA);
        if (state_n == S_FETCH)
            rd_addr_n = index_n;
        case (state_n)
            S_RST:   tx_data_n = 8'h02;
            S_HDR:   tx_data_n = 8'h01;
            S_DATA:  tx_data_n = shreg_n[7:0];
            default: tx_data_n = tx_data_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            index      <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            index      <= index_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            rd_en_q    <= rd_en_n;
            rd_addr_q  <= rd_addr_n;
            tx_valid_q <= tx_valid_n;
            tx_data_q  <= tx_data_n;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_serial_stream_tx.sv
// Directed bench for serial_stream_tx: scoreboard of expected bytes/addresses plus a record-receiver model.
`timescale 1ns/1ps
module tb_serial_stream_tx;
    localparam int DATA_L = 27;
    localparam int ADDR_W = 12;
    localparam int REC_W  = DATA_L * 8;
    localparam int REC_CYC = DATA_L + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_stream_tx_if #(.DATA_L(DATA_L), .ADDR_W(ADDR_W)) bus ();
    serial_stream_tx #(.DATA_L(DATA_L), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [REC_W-1:0]  mem [16];
    logic [REC_W-1:0]  rx_mem [16];
    logic [7:0]        exp_bytes [$];
    logic [ADDR_W-1:0] exp_addr [$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    int   rx_size = 0;
    int   rx_idx = 0;
    bit   rx_in_rec = 0;
    bit   rand_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[3:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, done counting and receiver model.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [7:0] b;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                rx_in_rec  = 0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {55'd0, bus.tx_valid, bus.tx_data}, {55'd0, 1'b1, prev_data});
                if (bus.rd_en === 1'b1) begin
                    chk("rd_addr_expected", 64'(exp_addr.size() != 0), 64'd1);
                    if (exp_addr.size() != 0)
                        chk("rd_addr", 64'(bus.rd_addr), 64'(exp_addr.pop_front()));
                end
                if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                    b = bus.tx_data;
                    chk("byte_expected", 64'(exp_bytes.size() != 0), 64'd1);
                    if (exp_bytes.size() != 0)
                        chk("tx_byte", 64'(b), 64'(exp_bytes.pop_front()));
                    if (rx_in_rec) begin
                        rx_mem[rx_size[3:0]][8*rx_idx +: 8] = b;
                        rx_idx++;
                        if (rx_idx == DATA_L) begin
                            rx_in_rec = 0;
                            rx_size++;
                        end
                    end else if (b == 8'h02) begin
                        rx_size = 0;
                    end else if (b == 8'h01) begin
                        rx_in_rec = 1;
                        rx_idx    = 0;
                    end
                end
                if (bus.done === 1'b1) done_cnt++;
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_data  = bus.tx_data;
            end
        end
    end

    task automatic push_stream(input int cnt, input bit clr);
        logic [REC_W-1:0] w;
        if (clr) exp_bytes.push_back(8'h02);
        for (int r = 0; r < cnt; r++) begin
            exp_addr.push_back(ADDR_W'(r));
            exp_bytes.push_back(8'h01);
            w = mem[r];
            for (int b = 0; b < DATA_L; b++) exp_bytes.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic start_stream(input int cnt, input bit clr);
        push_stream(cnt, clr);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.count = ADDR_W'(cnt);
        bus.clear = clr;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int lat);
        lat = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = cyc - start_cyc;
                break;
            end
        end
        chk("done_timeout", 64'(lat >= 0), 64'd1);
        if (lat >= 0) begin
            chk("busy_with_done", 64'(bus.busy), 64'd1);
            @(negedge clk);
            chk("busy_after_done", 64'(bus.busy), 64'd0);
            chk("done_one_cycle", 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        int lat;
        int d0;
        bus.start = 1'b0;
        bus.count = '0;
        bus.clear = 1'b0;
        for (int r = 0; r < 16; r++)
            for (int b = 0; b < DATA_L; b++) mem[r][8*b +: 8] = 8'($urandom);
        for (int b = 0; b < DATA_L; b++) mem[0][8*b +: 8] = 8'(b + 1);

        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // One record with reset-list prefix, ready tied high.
        start_stream(1, 1);
        wait_done(200, lat);
        chk("lat_c1_clr", 64'(lat), 64'(2 + REC_CYC));
        chk("queue_empty_c1", 64'(exp_bytes.size()), 64'd0);
        chk("rx_size_c1", 64'(rx_size), 64'd1);
        checks++;
        assert (rx_mem[0] === mem[0]) else begin
            errors++;
            $error("FAIL rx_rec0 got=%h exp=%h", rx_mem[0], mem[0]);
        end

        // Four records under random back-pressure.
        rand_mode = 1;
        start_stream(4, 0);
        wait_done(2000, lat);
        rand_mode = 0;
        chk("lat_c4_rand_min", 64'(lat >= 1 + 4 * REC_CYC), 64'd1);
        chk("queue_empty_c4", 64'(exp_bytes.size() + exp_addr.size()), 64'd0);

        // Empty streams.
        start_stream(0, 0);
        wait_done(20, lat);
        chk("lat_c0", 64'(lat), 64'd1);
        start_stream(0, 1);
        wait_done(20, lat);
        chk("lat_c0_clr", 64'(lat), 64'd2);
        chk("queue_empty_c0", 64'(exp_bytes.size()), 64'd0);

        // start while busy must be ignored.
        repeat (2) @(posedge clk);
        #1 d0 = done_cnt;
        start_stream(2, 0);
        repeat (20) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.count = ADDR_W'(5);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        wait_done(500, lat);
        chk("lat_ignore_start", 64'(lat), 64'(1 + 2 * REC_CYC));
        repeat (10) @(posedge clk);
        #1;
        chk("single_done", 64'(done_cnt - d0), 64'd1);
        chk("queue_empty_ign", 64'(exp_bytes.size() + exp_addr.size()), 64'd0);

        // Abort during the 10th data byte of record 1.
        start_stream(2, 0);
        while (cyc != start_cyc + 33 + 10) begin
            @(posedge clk);
            #1;
        end
        #1;
        chk("pre_abort_byte", {55'd0, bus.tx_valid, bus.tx_data}, {55'd0, 1'b1, mem[1][8*9 +: 8]});
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("abort_tx_data", 64'(bus.tx_data), 64'd0);
        chk("abort_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("abort_rd_en", 64'(bus.rd_en), 64'd0);
        exp_bytes.delete();
        exp_addr.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        start_stream(1, 1);
        wait_done(200, lat);
        chk("lat_restart", 64'(lat), 64'(2 + REC_CYC));
        chk("queue_empty_restart", 64'(exp_bytes.size() + exp_addr.size()), 64'd0);

        // Loopback into the receiver model.
        start_stream(3, 1);
        wait_done(500, lat);
        chk("lat_c3_clr", 64'(lat), 64'(2 + 3 * REC_CYC));
        chk("rx_size_c3", 64'(rx_size), 64'd3);
        for (int r = 0; r < 3; r++) begin
            checks++;
            assert (rx_mem[r] === mem[r]) else begin
                errors++;
                $error("FAIL rx_rec%0d got=%h exp=%h", r, rx_mem[r], mem[r]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
